// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - tx_state_e     : transmitter FSM state encoding
//   - DLEN_5..DLEN_8 : i_dlen encodings for 5..8 data bits
//   - FRAME_BITS_MAX : longest frame (start + 8 data + parity + 2 stop)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] DLEN_5 = 2'd0;
  localparam logic [1:0] DLEN_6 = 2'd1;
  localparam logic [1:0] DLEN_7 = 2'd2;
  localparam logic [1:0] DLEN_8 = 2'd3;

  localparam int FRAME_BITS_MAX = 1 + 8 + 1 + 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous show-ahead FIFO feeding the transmitter FSM (rdata is the head
// entry whenever empty is low).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   flush          synchronous clear of all entries
//   push, wdata    write request and data (ignored when full)
//   pop            consume head entry (ignored when empty)
//   rdata          head entry
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (i_rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full)  wptr_q <= wptr_q + (AW+1)'(1);
      if (pop  && !empty) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter. A single i_clk domain; a down-counting
// baud counter produces one tick per bit period (i_div+1 cycles). Frames are
// start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in
// front of the FSM (o_ready = not full, i_en low flushes it).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_en             enable; low aborts the frame and idles the line
//   i_div            bit period minus one, in i_clk cycles
//   i_dlen           data bits (DLEN_5..DLEN_8)
//   i_par_en         parity enable
//   i_par_odd        odd (1) / even (0) parity
//   i_stop2          two stop bits when high
//   i_valid, i_data  byte offer
//   o_ready          byte accepted this cycle if i_valid & i_en
//   o_busy           frame in progress (or FIFO holding data)
//   o_done           one-cycle pulse after the last stop bit
//   o_tx             serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int DATA_MAX   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [DIV_W-1:0]    i_div,
  input  logic [1:0]          i_dlen,
  input  logic                i_par_en,
  input  logic                i_par_odd,
  input  logic                i_stop2,
  input  logic                i_valid,
  input  logic [DATA_MAX-1:0] i_data,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_tx
);

  localparam int BIT_W = $clog2(FRAME_BITS_MAX);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e           state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, div_q;
  logic [1:0]          dlen_q;
  logic                par_en_q, par_odd_q, stop2_q;
  logic [DATA_MAX-1:0] shreg_q;
  logic [BIT_W-1:0]    bitcnt_q;
  logic [BIT_W-1:0]    last_data;
  logic                par_acc_q;
  logic                done_q;
  logic                load;
  logic                tick;
  logic                fsm_busy;
  logic [DATA_MAX-1:0] load_data;

  assign tick     = (cnt_q == '0);
  assign fsm_busy = (state_q != ST_IDLE);

`ifdef UART_TX_FIFO_EN
  logic fifo_push, fifo_full, fifo_empty;

  assign o_ready   = ~fifo_full & ~i_rst;
  assign fifo_push = i_valid & o_ready & i_en;
  assign load      = ~fsm_busy & ~fifo_empty & i_en;
  assign o_busy    = fsm_busy | ~fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .flush (~i_en),
    .push  (fifo_push),
    .wdata (i_data),
    .pop   (load),
    .rdata (load_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  // o_ready depends only on state, i_en and i_rst, never on i_valid.
  assign o_ready   = ~fsm_busy & i_en & ~i_rst;
  assign load      = i_valid & o_ready;
  assign load_data = i_data;
  assign o_busy    = fsm_busy;
`endif

  // Index of the final data bit for the latched length.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no
    // latch is inferred.
    last_data = BIT_W'(4);
    case (dlen_q)
      DLEN_5: last_data = BIT_W'(4);
      DLEN_6: last_data = BIT_W'(5);
      DLEN_7: last_data = BIT_W'(6);
      DLEN_8: last_data = BIT_W'(7);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:   if (tick && bitcnt_q == last_data)
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      // bitcnt counts completed stop bits: exit after 1 (stop2=0) or 2.
      ST_STOP:   if (tick && bitcnt_q == BIT_W'(stop2_q)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      ST_START:  o_tx = 1'b0;
      ST_DATA:   o_tx = shreg_q[0];
      ST_PARITY: o_tx = par_acc_q ^ par_odd_q;
      default:   o_tx = 1'b1;
    endcase
  end

  assign o_done = done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      dlen_q    <= DLEN_5;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      par_acc_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (!i_en) begin
      // Abort: drop the partial frame; it is never resumed.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_STOP) && (state_d == ST_IDLE);
      if (load) begin
        // Configuration is frozen here for the whole frame.
        cnt_q     <= i_div;
        div_q     <= i_div;
        dlen_q    <= i_dlen;
        par_en_q  <= i_par_en;
        par_odd_q <= i_par_odd;
        stop2_q   <= i_stop2;
        shreg_q   <= load_data;
        bitcnt_q  <= '0;
        par_acc_q <= 1'b0;
      end else if (fsm_busy) begin
        if (!tick) begin
          cnt_q <= cnt_q - DIV_W'(1);
        end else begin
          cnt_q <= div_q;
          case (state_q)
            ST_DATA: begin
              shreg_q   <= shreg_q >> 1;
              par_acc_q <= par_acc_q ^ shreg_q[0];
              bitcnt_q  <= (state_d == ST_DATA) ? bitcnt_q + BIT_W'(1) : '0;
            end
            ST_STOP: bitcnt_q <= bitcnt_q + BIT_W'(1);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg. A frame-level model expands every
// accepted byte into the per-cycle line waveform it must produce and is
// compared against o_tx/o_busy/o_done/o_ready on every cycle; directed tests
// add hand-computed literal expectations and a simple line receiver.
// Define UART_TX_FIFO_EN to build and test the FIFO variant.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int DIV_W      = 16;
  localparam int DATA_MAX   = 8;
  localparam int FIFO_DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst, en, par_en, par_odd, stop2, valid;
  logic [DIV_W-1:0]    div;
  logic [1:0]          dlen;
  logic [DATA_MAX-1:0] data;
  logic                ready, busy, done, tx;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DIV_W      (DIV_W),
    .DATA_MAX   (DATA_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_div     (div),
    .i_dlen    (dlen),
    .i_par_en  (par_en),
    .i_par_odd (par_odd),
    .i_stop2   (stop2),
    .i_valid   (valid),
    .i_data    (data),
    .o_ready   (ready),
    .o_busy    (busy),
    .o_done    (done),
    .o_tx      (tx)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit         exp_q[$];     // expected line level, one entry per remaining frame cycle
  logic [7:0] fifo_m[$];
  bit         m_done = 1'b0;
  bit         chk_on = 1'b0;

  task automatic build_frame(input logic [7:0] d);
    int reps;
    int nbits;
    bit p;
    reps  = int'(div) + 1;
    nbits = int'(dlen) + 5;
    p     = par_odd;
    for (int r = 0; r < reps; r++) exp_q.push_back(1'b0);
    for (int b = 0; b < nbits; b++) begin
      p ^= d[b];
      for (int r = 0; r < reps; r++) exp_q.push_back(d[b]);
    end
    if (par_en) for (int r = 0; r < reps; r++) exp_q.push_back(p);
    for (int s = 0; s < (stop2 ? 2 : 1); s++)
      for (int r = 0; r < reps; r++) exp_q.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (rst || !en) begin
      exp_q.delete();
      fifo_m.delete();
      m_done = 1'b0;
    end else begin
      bit idle;
      bit last;
      bit room;
      idle = (exp_q.size() == 0);
      last = (exp_q.size() == 1);
      room = (fifo_m.size() < FIFO_DEPTH);
      if (!idle) void'(exp_q.pop_front());
      m_done = last;
`ifdef UART_TX_FIFO_EN
      if (idle && fifo_m.size() > 0) build_frame(fifo_m.pop_front());
      if (valid && room) fifo_m.push_back(data);
`else
      if (idle && valid) build_frame(data);
`endif
    end
  end

  // ------------------------------------------------- compare + capture
  logic cap_tx[$], cap_done[$], cap_ready[$], cap_busy[$];
  bit   cap_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      bit m_tx, m_busy, m_ready;
      m_tx = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
`ifdef UART_TX_FIFO_EN
      m_busy  = (exp_q.size() > 0) || (fifo_m.size() > 0);
      m_ready = (fifo_m.size() < FIFO_DEPTH) && !rst;
`else
      m_busy  = (exp_q.size() > 0);
      m_ready = (exp_q.size() == 0) && en && !rst;
`endif
      check("model_tx",    tx,    m_tx);
      check("model_busy",  busy,  m_busy);
      check("model_done",  done,  m_done);
      check("model_ready", ready, m_ready);
    end
    if (cap_on) begin
      cap_tx.push_back(tx);
      cap_done.push_back(done);
      cap_ready.push_back(ready);
      cap_busy.push_back(busy);
    end
  end

  // -------------------------------------------------------- helpers
  logic [7:0] rx_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int l, input bit pe, input bit po, input bit s2);
    div = DIV_W'(d); dlen = 2'(l); par_en = pe; par_odd = po; stop2 = s2;
  endtask

  task automatic cap_start();
    cap_tx.delete(); cap_done.delete(); cap_ready.delete(); cap_busy.delete();
    cap_on = 1'b1;
  endtask

  task automatic send(input logic [7:0] v);
    valid = 1'b1;
    data  = v;
    step();
    valid = 1'b0;
    cap_start();
  endtask

  function automatic int count_done();
    int n = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [7:0] rx_at(input int k);
    return (k < rx_q.size()) ? rx_q[k] : 8'hxx;
  endfunction

  // Recovers bytes from the captured line by sampling mid-bit.
  task automatic rx_decode(input int dv, input int nbits, input int fbits);
    int i;
    int per;
    i   = 0;
    per = dv + 1;
    rx_q.delete();
    while (i < cap_tx.size()) begin
      if (cap_tx[i] === 1'b0 && i + fbits * per <= cap_tx.size()) begin
        logic [7:0] v;
        v = 8'h00;
        for (int b = 0; b < nbits; b++) v[b] = cap_tx[i + (b + 1) * per + dv / 2];
        rx_q.push_back(v);
        i += fbits * per;
      end else begin
        i++;
      end
    end
  endtask

  bit         lit_a5 [10];
  bit         lit_par [9];
  logic [7:0] fifo_bytes [8];
  logic       rdy_seen [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; data = '0;
    set_cfg(0, 3, 0, 0, 0);
    step();
    step();
    chk_on = 1'b1;

    // Reset state (i_rst still high).
    @(negedge clk);
    check("rst_tx",    tx,    1'b1);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_ready", ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready, 1'b1);
    step();

`ifndef UART_TX_FIFO_EN
    // Basic frame: 0xA5, div=3, 8N1.
    lit_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    set_cfg(3, 3, 0, 0, 0);
    send(8'hA5);
    repeat (45) step();
    cap_on = 1'b0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 4; c++)
        check($sformatf("a5_bit%0d_c%0d", b, c), cap_tx[b * 4 + c], lit_a5[b]);
    check("a5_done_cycle41", cap_done[40], 1'b1);
    check("a5_done_count", count_done(), 1);
    check("a5_idle_after", cap_tx[41], 1'b1);

    // Parity and two stop bits: 0x13, div=0, 5 data bits, odd parity.
    lit_par = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    set_cfg(0, 0, 1, 1, 1);
    send(8'h13);
    repeat (12) step();
    cap_on = 1'b0;
    for (int k = 0; k < 9; k++) check($sformatf("par_seq%0d", k), cap_tx[k], lit_par[k]);
    check("par_done_cycle10", cap_done[9], 1'b1);
    check("par_done_count", count_done(), 1);

    // Back-to-back with i_valid held: 0x55 then 0xAA, div=1, 8N1.
    set_cfg(1, 3, 0, 0, 0);
    valid = 1'b1;
    data  = 8'h55;
    step();
    data = 8'hAA;
    cap_start();
    repeat (21) step();
    valid = 1'b0;
    repeat (25) step();
    cap_on = 1'b0;
    check("b2b_ready_stop",  cap_ready[19], 1'b0);
    check("b2b_ready_idle",  cap_ready[20], 1'b1);
    check("b2b_done_idle",   cap_done[20],  1'b1);
    check("b2b_idle_high",   cap_tx[20],    1'b1);
    check("b2b_second_start", cap_tx[21],   1'b0);
    rx_decode(1, 8, 10);
    check("b2b_rx_count", rx_q.size(), 2);
    check("b2b_rx0", rx_at(0), 8'h55);
    check("b2b_rx1", rx_at(1), 8'hAA);
    check("b2b_done_count", count_done(), 2);

    // Abort during the third data bit, with i_valid offered during the abort.
    set_cfg(3, 3, 0, 0, 0);
    send(8'hC3);
    repeat (13) step();
    cap_on = 1'b0;
    en    = 1'b0;
    valid = 1'b1;
    data  = 8'hFF;
    step();
    @(negedge clk);
    check("abort_tx",    tx,    1'b1);
    check("abort_busy",  busy,  1'b0);
    check("abort_done",  done,  1'b0);
    check("abort_ready", ready, 1'b0);
    step();
    en    = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("abort_no_accept_busy", busy, 1'b0);
    check("abort_no_done",        done, 1'b0);
    step();
    set_cfg(1, 3, 0, 0, 0);
    send(8'h0F);
    repeat (24) step();
    cap_on = 1'b0;
    rx_decode(1, 8, 10);
    check("abort_rx_count", rx_q.size(), 1);
    check("abort_rx0", rx_at(0), 8'h0F);

    // Reset during the parity bit: 0x2D, 6 data bits, even parity (bit = 0).
    set_cfg(2, 1, 1, 0, 0);
    send(8'h2D);
    repeat (22) step();
    cap_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_parity_bit", tx,    1'b0);
    check("rstmid_ready_low",  ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_tx",    tx,    1'b1);
    check("rstmid_busy",  busy,  1'b0);
    check("rstmid_done",  done,  1'b0);
    check("rstmid_ready", ready, 1'b1);
    step();
    set_cfg(0, 3, 0, 0, 0);
    send(8'h3C);
    repeat (14) step();
    cap_on = 1'b0;
    rx_decode(0, 8, 10);
    check("rstmid_rx_count", rx_q.size(), 1);
    check("rstmid_rx0", rx_at(0), 8'h3C);
`else
    // FIFO: a primer frame keeps the FSM busy while 9 pushes are offered;
    // 8 fill the FIFO and the 9th sees o_ready low.
    fifo_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    set_cfg(0, 3, 0, 0, 0);
    valid = 1'b1;
    data  = 8'h11;
    step();
    valid = 1'b0;
    step();
    cap_start();
    for (int k = 0; k < 9; k++) begin
      valid       = 1'b1;
      data        = (k < 8) ? fifo_bytes[k] : 8'h99;
      rdy_seen[k] = ready;
      step();
    end
    valid = 1'b0;
    repeat (110) step();
    cap_on = 1'b0;
    for (int k = 0; k < 8; k++) check($sformatf("fifo_ready%0d", k), rdy_seen[k], 1'b1);
    check("fifo_ready_full", rdy_seen[8], 1'b0);
    rx_decode(0, 8, 10);
    check("fifo_rx_count", rx_q.size(), 9);
    check("fifo_rx_primer", rx_at(0), 8'h11);
    for (int k = 0; k < 8; k++) check($sformatf("fifo_rx%0d", k), rx_at(k + 1), fifo_bytes[k]);
    check("fifo_done_count", count_done() - 1, 8);
    begin
      int last_d;
      int gaps;
      last_d = 0;
      gaps   = 0;
      foreach (cap_done[i]) if (cap_done[i] === 1'b1) last_d = i;
      for (int i = 0; i < last_d; i++) if (cap_busy[i] !== 1'b1) gaps++;
      check("fifo_busy_held", gaps, 0);
      check("fifo_last_done_cycle", last_d, 9 * 11 - 1);
    end
`endif

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
